dmem_access_ctrl: RTL and testbench

Data-memory access controller directly downstream of the memory stage.
- Consumes the memory stage's request, we_re, mask, address and aligned store data.
- Runs a valid/ready transaction on the data-memory bus and returns the load word with a data_valid pulse for load wrapping.
- Stalls the pipeline while an access is outstanding.

---
 rtl/dmem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: data-memory access controller sitting behind the memory
// stage. Issues one valid/ready bus transaction per request, returns load
// words with a data_valid pulse and stalls the pipeline while busy.
// Optional feature macro: DMEM_TIMEOUT_EN (abort REQ/WAIT after TIMEOUT cycles).
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                request,
    input  logic                we_re,
    input  logic [DATA_W/8-1:0] mask,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   store_data,
    output logic                stall,
    output logic                data_valid,
    output logic [DATA_W-1:0]   load_data,
    output logic                err,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W/8-1:0] m_wmask,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_load_data;
    logic                  w_timeout;
    logic                  w_abort;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]      r_cnt;
    logic                  r_err;

    // Last allowed REQ/WAIT cycle reached: counter starts at 0 on entry,
    // so TIMEOUT cycles have elapsed when it reads TIMEOUT-1.
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT - 1));

    // Cycle counter for the outstanding access; cleared when a new access starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && request) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ || r_state == S_WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // err is high exactly for the DONE cycle that follows an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Abort happens only when the access did not complete in this cycle.
    assign w_abort = w_timeout &&
                     ((r_state == S_REQ  && !m_req_ready) ||
                      (r_state == S_WAIT && !m_rsp_valid));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a store completes at the request handshake (posted write).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (request) w_next = S_REQ;
            S_REQ: begin
                if (m_req_ready)    w_next = r_we ? S_DONE : S_WAIT;
                else if (w_timeout) w_next = S_DONE;
            end
            S_WAIT: begin
                if (m_rsp_valid || w_timeout) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the access when it is accepted in IDLE; loads never carry strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && request) begin
            r_we    <= we_re;
            r_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_wmask <= we_re ? mask : '0;
            r_wdata <= store_data;
        end
    end

    // Load word register: updated only by a response in WAIT or a load abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_data <= '0;
        end else if (r_state == S_WAIT && m_rsp_valid) begin
            r_load_data <= m_rsp_data;
        end else if (w_abort && !r_we) begin
            r_load_data <= '0;
        end
    end

    assign m_req_valid = (r_state == S_REQ);
    assign m_we        = r_we;
    assign m_addr      = r_addr;
    assign m_wmask     = r_wmask;
    assign m_wdata     = r_wdata;
    assign load_data   = r_load_data;
    assign data_valid  = (r_state == S_DONE) && !r_we;
    assign stall       = (r_state == S_IDLE && request) ||
                         (r_state == S_REQ) || (r_state == S_WAIT);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: per-cycle vector table plus hand-written
// sequences for reset mid-access and the timeout / no-timeout wait.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        request;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic        data_valid;
    logic [31:0] load_data;
    logic        err;
    logic        m_req_valid;
    logic        m_req_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;

    int total = 0;
    int bad   = 0;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .addr(addr), .store_data(store_data), .stall(stall),
        .data_valid(data_valid), .load_data(load_data), .err(err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_we(m_we),
        .m_addr(m_addr), .m_wmask(m_wmask), .m_wdata(m_wdata),
        .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  msk;
        logic [31:0] ad;
        logic [31:0] sd;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        e_stall;
        logic        e_dv;
        logic [31:0] e_ld;
        logic        e_mv;
        logic        e_mwe;
        logic [31:0] e_maddr;
        logic [3:0]  e_wm;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic rq, logic w, logic [3:0] mk, logic [31:0] a,
                                logic [31:0] s, logic rdy, logic rv, logic [31:0] rd,
                                logic es, logic edv, logic [31:0] eld, logic emv,
                                logic emwe, logic [31:0] ema, logic [3:0] ewm,
                                logic [31:0] ewd);
        vec_t v;
        v.req = rq; v.we = w; v.msk = mk; v.ad = a; v.sd = s;
        v.rdy = rdy; v.rv = rv; v.rd = rd;
        v.e_stall = es; v.e_dv = edv; v.e_ld = eld; v.e_mv = emv;
        v.e_mwe = emwe; v.e_maddr = ema; v.e_wm = ewm; v.e_wd = ewd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rq, input logic w, input logic [3:0] mk,
                         input logic [31:0] a, input logic [31:0] s,
                         input logic rdy, input logic rv, input logic [31:0] rd);
        request = rq; we_re = w; mask = mk; addr = a; store_data = s;
        m_req_ready = rdy; m_rsp_valid = rv; m_rsp_data = rd;
    endtask

    int hs;

    initial begin
        rst = 1'b0;
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_dv", {31'h0, data_valid}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_mv", {31'h0, m_req_valid}, 32'h0);
        chk("rst_mwe", {31'h0, m_we}, 32'h0);
        chk("rst_maddr", m_addr, 32'h0);
        chk("rst_wmask", {28'h0, m_wmask}, 32'h0);
        chk("rst_wdata", m_wdata, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ---- vector table: one entry per cycle ----
        //  req we msk  addr          sd            rdy rv rd            | stall dv ld            mv mwe maddr         wm    wd
        // load, zero-wait bus
        add(1, 0, 4'hF, 32'h0000_1006, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0,         4'h0, 32'h0);
        add(1, 0, 4'hF, 32'h0000_1006, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0000_1004, 4'h0, 32'h0);
        add(1, 0, 4'hF, 32'h0000_1006, 32'h0,         0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 0, 32'h0000_1004, 4'h0, 32'h0);
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 4'h0, 32'h0);
        // spurious response in IDLE
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 1, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 4'h0, 32'h0);
        // store with 4 cycles of backpressure (plus a stray response)
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_1004, 4'h0, 32'h0);
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 0, 1, 32'h1111_1111, 1, 0, 32'hDEAD_BEEF, 1, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(1, 1, 4'hC, 32'h0000_2000, 32'hABCD_0000, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 0, 32'hDEAD_BEEF, 0, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        // back-to-back: load then store with request held high
        add(1, 0, 4'hF, 32'h0000_3008, 32'h0,         0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 1, 32'h0000_2000, 4'hC, 32'hABCD_0000);
        add(1, 0, 4'hF, 32'h0000_3008, 32'h0,         1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 1, 0, 32'h0000_3008, 4'h0, 32'h0);
        add(1, 0, 4'hF, 32'h0000_3008, 32'h0,         0, 1, 32'hCAFE_F00D, 1, 0, 32'hDEAD_BEEF, 0, 0, 32'h0000_3008, 4'h0, 32'h0);
        add(1, 1, 4'h3, 32'h0000_400A, 32'h0000_BEEF, 0, 0, 32'h0,         0, 1, 32'hCAFE_F00D, 0, 0, 32'h0000_3008, 4'h0, 32'h0);
        add(1, 1, 4'h3, 32'h0000_400A, 32'h0000_BEEF, 0, 0, 32'h0,         1, 0, 32'hCAFE_F00D, 0, 0, 32'h0000_3008, 4'h0, 32'h0);
        add(1, 1, 4'h3, 32'h0000_400A, 32'h0000_BEEF, 1, 0, 32'h0,         1, 0, 32'hCAFE_F00D, 1, 1, 32'h0000_4008, 4'h3, 32'h0000_BEEF);
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 0, 32'hCAFE_F00D, 0, 1, 32'h0000_4008, 4'h3, 32'h0000_BEEF);
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 0, 32'hCAFE_F00D, 0, 1, 32'h0000_4008, 4'h3, 32'h0000_BEEF);
        // store with mask=0 still issued unchanged
        add(1, 1, 4'h0, 32'h0000_0010, 32'h0000_0077, 0, 0, 32'h0,         1, 0, 32'hCAFE_F00D, 0, 1, 32'h0000_4008, 4'h3, 32'h0000_BEEF);
        add(1, 1, 4'h0, 32'h0000_0010, 32'h0000_0077, 1, 0, 32'h0,         1, 0, 32'hCAFE_F00D, 1, 1, 32'h0000_0010, 4'h0, 32'h0000_0077);
        add(0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         0, 0, 32'hCAFE_F00D, 0, 1, 32'h0000_0010, 4'h0, 32'h0000_0077);

        hs = 0;
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].req, vq[i].we, vq[i].msk, vq[i].ad, vq[i].sd,
                  vq[i].rdy, vq[i].rv, vq[i].rd);
            #1;
            chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vq[i].e_stall});
            chk($sformatf("v%0d_dv", i), {31'h0, data_valid}, {31'h0, vq[i].e_dv});
            chk($sformatf("v%0d_ld", i), load_data, vq[i].e_ld);
            chk($sformatf("v%0d_mv", i), {31'h0, m_req_valid}, {31'h0, vq[i].e_mv});
            chk($sformatf("v%0d_mwe", i), {31'h0, m_we}, {31'h0, vq[i].e_mwe});
            chk($sformatf("v%0d_maddr", i), m_addr, vq[i].e_maddr);
            chk($sformatf("v%0d_wmask", i), {28'h0, m_wmask}, {28'h0, vq[i].e_wm});
            chk($sformatf("v%0d_wdata", i), m_wdata, vq[i].e_wd);
            chk($sformatf("v%0d_err", i), {31'h0, err}, 32'h0);
            if (m_req_valid && m_req_ready) hs++;
        end
        chk("handshakes", hs, 32'd5);

        // ---- reset asserted mid-WAIT, then a late response ----
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0500, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0500, 32'h0, 1, 0, 32'h0);
        #1;
        chk("rw_req_mv", {31'h0, m_req_valid}, 32'h1);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0500, 32'h0, 0, 0, 32'h0);
        #1;
        chk("rw_wait_stall", {31'h0, stall}, 32'h1);
        chk("rw_wait_mv", {31'h0, m_req_valid}, 32'h0);
        request = 1'b0;
        rst = 1'b0;
        #1;
        chk("rw_rst_stall", {31'h0, stall}, 32'h0);
        chk("rw_rst_dv", {31'h0, data_valid}, 32'h0);
        chk("rw_rst_mv", {31'h0, m_req_valid}, 32'h0);
        chk("rw_rst_mwe", {31'h0, m_we}, 32'h0);
        chk("rw_rst_maddr", m_addr, 32'h0);
        chk("rw_rst_wmask", {28'h0, m_wmask}, 32'h0);
        chk("rw_rst_wdata", m_wdata, 32'h0);
        chk("rw_rst_ld", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h9999_9999);
            #1;
            chk($sformatf("late%0d_dv", k), {31'h0, data_valid}, 32'h0);
            chk($sformatf("late%0d_ld", k), load_data, 32'h0);
            chk($sformatf("late%0d_stall", k), {31'h0, stall}, 32'h0);
            chk($sformatf("late%0d_mv", k), {31'h0, m_req_valid}, 32'h0);
            @(negedge clk);
        end
        drive(1, 0, 4'hF, 32'h0000_0704, 32'h0, 0, 0, 32'h0);
        #1;
        chk("post_idle_stall", {31'h0, stall}, 32'h1);
        chk("post_idle_mv", {31'h0, m_req_valid}, 32'h0);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0704, 32'h0, 1, 0, 32'h0);
        #1;
        chk("post_req_mv", {31'h0, m_req_valid}, 32'h1);
        chk("post_req_maddr", m_addr, 32'h0000_0704);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0704, 32'h0, 0, 1, 32'h0A0B_0C0D);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("post_done_dv", {31'h0, data_valid}, 32'h1);
        chk("post_done_ld", load_data, 32'h0A0B_0C0D);

        // ---- load whose response never arrives ----
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0600, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0600, 32'h0, 1, 0, 32'h0);
        #1;
        chk("to_req_stall", {31'h0, stall}, 32'h1);
        chk("to_req_err", {31'h0, err}, 32'h0);
`ifdef DMEM_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            drive(1, 0, 4'hF, 32'h0000_0600, 32'h0, 0, 0, 32'h0);
            #1;
            chk($sformatf("to_wait%0d_stall", k), {31'h0, stall}, 32'h1);
            chk($sformatf("to_wait%0d_err", k), {31'h0, err}, 32'h0);
        end
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("to_done_err", {31'h0, err}, 32'h1);
        chk("to_done_dv", {31'h0, data_valid}, 32'h1);
        chk("to_done_ld", load_data, 32'h0);
        chk("to_done_stall", {31'h0, stall}, 32'h0);
        chk("to_done_mv", {31'h0, m_req_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("to_idle_err", {31'h0, err}, 32'h0);
        chk("to_idle_dv", {31'h0, data_valid}, 32'h0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1, 0, 4'hF, 32'h0000_0600, 32'h0, 0, 0, 32'h0);
            #1;
            chk($sformatf("nt_wait%0d_stall", k), {31'h0, stall}, 32'h1);
            chk($sformatf("nt_wait%0d_err", k), {31'h0, err}, 32'h0);
            chk($sformatf("nt_wait%0d_mv", k), {31'h0, m_req_valid}, 32'h0);
        end
        @(negedge clk);
        drive(1, 0, 4'hF, 32'h0000_0600, 32'h0, 0, 1, 32'h600D_F00D);
        @(negedge clk);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("nt_done_dv", {31'h0, data_valid}, 32'h1);
        chk("nt_done_ld", load_data, 32'h600D_F00D);
        chk("nt_done_err", {31'h0, err}, 32'h0);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
